// File: rtl/imem_ctrl_pkg.sv
// Shared constants and types for the instruction-memory controller.
package imem_ctrl_pkg;

  localparam int INST_SIZE = 14;

  localparam logic [2:0] MODE_STALL = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_EXEC  = 3'd2;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LEN,
    LD_DATA,
    LD_ERR
  } imem_ld_state_t;

endpackage

// File: rtl/imem_ctrl_byte_packer.sv
// Little-endian 4-byte assembler: word_vld fires combinationally with the 4th byte.
// Accepts one byte per cycle with no backpressure; clr resets the byte index.
module imem_ctrl_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  idx;
  logic [23:0] lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      lo  <= '0;
    end else if (clr) begin
      idx <= '0;
      lo  <= '0;
    end else if (byte_vld) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    lo[7:0]   <= byte_dat;
        2'd1:    lo[15:8]  <= byte_dat;
        2'd2:    lo[23:16] <= byte_dat;
        default: ;
      endcase
    end
  end

  assign word_vld = byte_vld && (idx == 2'd3);
  assign word_dat = {byte_dat, lo};

endmodule

// File: rtl/imem_ctrl.sv
// Shares the instruction BRAM port between the UART program loader and fetch.
// Fetch: 1-cycle latency, throughput 1; loader writes one cycle after each 4th byte, never stalls rx.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = INST_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_inst,
  output logic              fetch_valid,
  output logic              fetch_misalign,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic              bram_we,
  input  logic [31:0]       bram_dout
);

  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  imem_ld_state_t    state, state_n;
  logic              is_load, is_exec, exec_req;
  logic              arm, abort, done_set;
  logic              byte_acc, word_vld, wr_fire, pk_clr;
  logic [31:0]       word;
  logic [ADDR_W:0]   n_q, wcnt;
  logic [ADDR_W-1:0] addr_q, pc_idx;
  logic [31:0]       din_q, hold_q;
  logic              we_q, fv_q, mis_q, done_q, err_q;
  logic              unused_pc;

  assign is_load   = (mode == MODE_LOAD);
  assign is_exec   = (mode == MODE_EXEC);
  assign exec_req  = is_exec && fetch_req && !rst;
  assign pc_idx    = fetch_pc[ADDR_W+1:2];
  assign unused_pc = ^fetch_pc[31:ADDR_W+2];

  // Bytes arriving after the last word has been issued are dropped.
  assign byte_acc = rx_valid && is_load &&
                    ((state == LD_LEN) || ((state == LD_DATA) && (wcnt != n_q)));
  assign pk_clr   = (state == LD_IDLE) || (state == LD_ERR);
  assign wr_fire  = (state == LD_DATA) && word_vld;

  imem_ctrl_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .byte_vld (byte_acc),
    .byte_dat (rx_data),
    .word_vld (word_vld),
    .word_dat (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LD_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    abort    = 1'b0;
    done_set = 1'b0;
    case (state)
      LD_IDLE: if (is_load && arm) state_n = LD_LEN;
      LD_LEN: begin
        if (!is_load) begin
          state_n = LD_IDLE;
          abort   = 1'b1;
        end else if (word_vld) begin
          if (word == 32'd0) begin
            state_n  = LD_IDLE;
            done_set = 1'b1;
          end else if ({1'b0, word} > CAP) begin
            state_n = LD_ERR;
          end else begin
            state_n = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        // The final write is already on the port once wcnt reaches N.
        if (wcnt == n_q) begin
          state_n  = LD_IDLE;
          done_set = 1'b1;
        end else if (!is_load) begin
          state_n = LD_IDLE;
          abort   = 1'b1;
        end
      end
      LD_ERR:  if (!is_load) state_n = LD_IDLE;
      default: state_n = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm    <= 1'b1;
      n_q    <= '0;
      wcnt   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
      din_q  <= '0;
      addr_q <= '0;
      fv_q   <= 1'b0;
      mis_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      // A new load needs mode to leave LOAD and come back.
      if (!is_load)                                    arm <= 1'b1;
      else if (state == LD_IDLE && state_n == LD_LEN)  arm <= 1'b0;

      if (state == LD_LEN && word_vld) begin
        n_q  <= word[ADDR_W:0];
        wcnt <= '0;
      end else if (wr_fire) begin
        wcnt <= wcnt + (ADDR_W+1)'(1);
      end

      done_q <= done_set;
      err_q  <= (state_n == LD_ERR) || abort;

      we_q <= wr_fire;
      if (wr_fire) din_q <= word;

      if (exec_req)     addr_q <= pc_idx;
      else if (wr_fire) addr_q <= wcnt[ADDR_W-1:0];

      fv_q  <= exec_req;
      mis_q <= exec_req && (fetch_pc[1:0] != 2'd0);
      if (fv_q) hold_q <= bram_dout;
    end
  end

  // A fetch owns the port outright; a late loader write cannot corrupt it.
  assign bram_addr      = exec_req ? pc_idx : addr_q;
  assign bram_we        = we_q && !exec_req;
  assign bram_din       = din_q;
  assign fetch_valid    = fv_q;
  assign fetch_misalign = mis_q;
  assign fetch_inst     = fv_q ? bram_dout : hold_q;
  assign load_busy      = (state == LD_LEN) || (state == LD_DATA);
  assign load_done      = done_q;
  assign load_err       = err_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized bench for imem_ctrl with a behavioural BRAM and a word-level memory model.
module tb_imem_ctrl;
  import imem_ctrl_pkg::*;

  localparam int AW  = 6;
  localparam int CAP = 1 << AW;

  typedef logic [31:0] wlist_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    mode;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_inst;
  logic          fetch_valid;
  logic          fetch_misalign;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic          bram_we;
  logic [31:0]   bram_dout;

  imem_ctrl #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .fetch_inst     (fetch_inst),
    .fetch_valid    (fetch_valid),
    .fetch_misalign (fetch_misalign),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_err       (load_err),
    .bram_addr      (bram_addr),
    .bram_din       (bram_din),
    .bram_we        (bram_we),
    .bram_dout      (bram_dout)
  );

  always #5 clk = ~clk;

  // Registered-read BRAM; contents cleared while reset is held.
  logic [31:0] bram_mem [CAP];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAP; i++) bram_mem[i] <= '0;
      bram_dout <= '0;
    end else begin
      if (bram_we) bram_mem[bram_addr] <= bram_din;
      bram_dout <= bram_mem[bram_addr];
    end
  end

  // Event monitor.
  int            done_cnt = 0;
  int            err_cnt  = 0;
  int            fv_cnt   = 0;
  logic          busy_at_done = 1'b1;
  logic [AW-1:0] wq_a[$];
  logic [31:0]   wq_d[$];

  always @(negedge clk) begin
    if (bram_we) begin
      wq_a.push_back(bram_addr);
      wq_d.push_back(bram_din);
    end
    if (load_done) begin
      done_cnt++;
      busy_at_done = load_busy;
    end
    if (load_err)    err_cnt++;
    if (fetch_valid) fv_cnt++;
  end

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] ref_mem [CAP];
  logic [31:0] last_inst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_inst"},   fetch_inst, 0);
    chk({p, "_fv"},     32'(fetch_valid), 0);
    chk({p, "_mis"},    32'(fetch_misalign), 0);
    chk({p, "_busy"},   32'(load_busy), 0);
    chk({p, "_done"},   32'(load_done), 0);
    chk({p, "_err"},    32'(load_err), 0);
    chk({p, "_addr"},   32'(bram_addr), 0);
    chk({p, "_din"},    bram_din, 0);
    chk({p, "_we"},     32'(bram_we), 0);
  endtask

  task automatic start_load();
    mode = MODE_STALL;
    tick();
    mode = MODE_LOAD;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic run_load(input string tag, input wlist_t prog, input bit gaps);
    int d0, b0, n;
    d0 = done_cnt;
    b0 = wq_a.size();
    n  = prog.size();
    start_load();
    send_word(32'(n), gaps);
    foreach (prog[i]) send_word(prog[i], gaps);
    for (int c = 0; c < 40 && done_cnt == d0; c++) @(negedge clk);
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
    repeat (3) tick();
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 1);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
    chk({tag, "_nwr"}, 32'(wq_a.size() - b0), 32'(n));
    for (int i = 0; i < n && b0 + i < wq_a.size(); i++) begin
      chk({tag, "_wr_addr"}, 32'(wq_a[b0+i]), 32'(i));
      chk({tag, "_wr_data"}, wq_d[b0+i], prog[i]);
    end
    foreach (prog[i]) ref_mem[i] = prog[i];
  endtask

  task automatic run_fetch(input string tag, input wlist_t pcs, input bit gaps);
    int          i;
    bit          pend, issue;
    logic [31:0] ppc, cpc, exp;
    i = 0; pend = 0; ppc = 0; cpc = 0;
    mode = MODE_EXEC;
    while (i < pcs.size() || pend) begin
      issue = 0;
      if (i < pcs.size() && !(gaps && $urandom_range(0, 3) == 0)) begin
        issue = 1;
        cpc   = pcs[i];
        i++;
      end
      fetch_req = issue;
      fetch_pc  = issue ? cpc : $urandom;
      @(negedge clk);
      if (pend) begin
        exp = ref_mem[(ppc / 4) % CAP];
        chk({tag, "_valid"}, 32'(fetch_valid), 1);
        chk({tag, "_inst"},  fetch_inst, exp);
        chk({tag, "_mis"},   32'(fetch_misalign), 32'(ppc % 4 != 0));
        last_inst = exp;
      end else begin
        chk({tag, "_idle_valid"}, 32'(fetch_valid), 0);
        chk({tag, "_hold"},       fetch_inst, last_inst);
      end
      pend = issue;
      ppc  = cpc;
      @(posedge clk);
      #1;
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wlist_t      prog, pcs, empty;
    int          b0, e0, d0, f0;
    logic [31:0] w0, w1;

    for (int i = 0; i < CAP; i++) ref_mem[i] = '0;
    last_inst = '0;
    rst = 1'b1; mode = MODE_STALL; rx_valid = 1'b0; rx_data = '0;
    fetch_req = 1'b0; fetch_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst = 1'b0;
    tick();

    prog = '{32'h12345678, 32'hDEADBEEF, 32'h00000001};
    run_load("ld3", prog, 1'b0);
    pcs = '{32'h0, 32'h4, 32'h8};
    run_fetch("f3", pcs, 1'b0);
    pcs = '{32'h6, 32'(4 + 4 * CAP)};
    run_fetch("fmis", pcs, 1'b0);

    for (int r = 0; r < 3; r++) begin
      prog.delete();
      repeat ($urandom_range(1, 8)) prog.push_back($urandom);
      run_load("ldr", prog, 1'b1);
      pcs.delete();
      repeat (30) pcs.push_back($urandom);
      run_fetch("fr", pcs, 1'b1);
    end

    prog.delete();
    repeat (CAP) prog.push_back($urandom);
    run_load("ldfull", prog, 1'b0);
    pcs.delete();
    repeat (40) pcs.push_back($urandom);
    run_fetch("ffull", pcs, 1'b0);

    // Oversized length goes to ERR and never writes.
    b0 = wq_a.size();
    start_load();
    send_word(32'(CAP + 1), 1'b0);
    chk("err_level", 32'(load_err), 1);
    chk("err_busy", 32'(load_busy), 0);
    send_word(32'hA5A5A5A5, 1'b1);
    chk("err_hold", 32'(load_err), 1);
    chk("err_nowr", 32'(wq_a.size() - b0), 0);
    mode = MODE_STALL;
    tick();
    chk("err_clear", 32'(load_err), 0);

    // Abort after 5 data bytes, with fetch requests ignored during LOAD.
    b0 = wq_a.size(); e0 = err_cnt; d0 = done_cnt; f0 = fv_cnt;
    w0 = $urandom; w1 = $urandom;
    start_load();
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    send_word(32'd4, 1'b0);
    send_word(w0, 1'b1);
    send_byte(w1[7:0], 1'b0);
    mode = MODE_STALL;
    repeat (3) tick();
    fetch_req = 1'b0;
    chk("abort_err_pulse", 32'(err_cnt - e0), 1);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_no_fetch", 32'(fv_cnt - f0), 0);
    chk("abort_nwr", 32'(wq_a.size() - b0), 1);
    if (wq_a.size() > b0) begin
      chk("abort_wr_addr", 32'(wq_a[b0]), 0);
      chk("abort_wr_data", wq_d[b0], w0);
    end
    ref_mem[0] = w0;

    // Fetch in flight when mode leaves EXEC still completes.
    mode = MODE_EXEC;
    fetch_req = 1'b1;
    fetch_pc  = 32'h8;
    tick();
    fetch_req = 1'b0;
    mode = MODE_STALL;
    @(negedge clk);
    chk("inflight_valid", 32'(fetch_valid), 1);
    chk("inflight_inst", fetch_inst, ref_mem[2]);
    tick();

    // Asynchronous reset mid-DATA, then an empty program.
    start_load();
    send_word(32'd4, 1'b0);
    send_word($urandom, 1'b0);
    send_byte(8'h11, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_zero("arst");
    mode = MODE_STALL;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < CAP; i++) ref_mem[i] = '0;
    last_inst = '0;
    tick();
    run_load("ld0", empty, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
